// File: rtl/sha256_mem_responder_if.sv
// Bus bundle between the SHA-256 engine/host side and the memory responder:
// engine memory master port plus the host load/unload request port.
interface sha256_mem_responder_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;

  modport master (
    output mem_addr, mem_we, mem_write_data,
    input  mem_read_data,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid
  );

  modport slave (
    input  mem_addr, mem_we, mem_write_data,
    output mem_read_data,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/sha256_mem_responder.sv
// Word-addressed message/result memory shared between a host port and the
// SHA-256 engine, with ownership FSM and digest write-back window tracking.
module sha256_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int OUT_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_mem_responder_if.slave bus,
  input  logic                 engine_start,
  input  logic [15:0]          win_base,
  output logic                 result_ready,
  input  logic                 result_clear,
  output logic                 oob_err,
  output logic                 conflict_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);
  localparam logic [16:0] OUT17   = 17'(OUT_WORDS);

  typedef enum logic [1:0] {ST_HOST, ST_ENGINE, ST_COMPLETE} state_t;

  state_t                 state_q, state_d;
  logic [OUT_WORDS-1:0]   mask_q, mask_d, win_bits;
  logic [15:0]            base_q;
  logic [31:0]            mem [DEPTH];

  logic        host_fire, host_in_range, eng_in_range, eng_owner;
  logic        eng_wr_ok, host_wr_ok, eng_access, win_hit;
  logic [16:0] addr17, base17, off17;
  logic [AW-1:0] eng_idx, host_idx;

  assign bus.host_ready = (state_q != ST_ENGINE);
  assign result_ready   = (state_q == ST_COMPLETE);

  assign host_fire     = bus.host_valid && bus.host_ready;
  assign host_in_range = {1'b0, bus.host_addr} < DEPTH17;
  assign eng_in_range  = {1'b0, bus.mem_addr} < DEPTH17;
  assign eng_owner     = (state_q == ST_ENGINE);
  assign eng_wr_ok     = eng_owner && bus.mem_we && eng_in_range;
  assign host_wr_ok    = host_fire && bus.host_we && host_in_range;
  // Engine address only counts as an access when it owns memory or actually writes.
  assign eng_access    = eng_owner || bus.mem_we;
  assign eng_idx       = bus.mem_addr[AW-1:0];
  assign host_idx      = bus.host_addr[AW-1:0];

  // Window compare is done one bit wider so base+OUT_WORDS never wraps.
  assign addr17  = {1'b0, bus.mem_addr};
  assign base17  = {1'b0, base_q};
  assign off17   = addr17 - base17;
  assign win_hit = (addr17 >= base17) && (off17 < OUT17);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block can leave it holding a value (no latch inferred).
    win_bits = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if (win_hit && (off17 == 17'(i))) win_bits[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_HOST: begin
        if (engine_start) begin
          state_d = ST_ENGINE;
          mask_d  = '0;
        end
      end
      ST_ENGINE: begin
        if (bus.mem_we) mask_d = mask_q | win_bits;
        if (&mask_d) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        // Clear wins over a coincident start: start is only honoured in HOST.
        if (result_clear) begin
          state_d = ST_HOST;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = ST_HOST;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q           <= ST_HOST;
      mask_q            <= '0;
      base_q            <= '0;
      bus.mem_read_data <= '0;
      bus.host_rdata    <= '0;
      bus.host_rvalid   <= 1'b0;
      oob_err           <= 1'b0;
      conflict_err      <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      bus.host_rvalid <= host_fire && !bus.host_we;
      if (state_q == ST_HOST && engine_start) base_q <= win_base;
      if (host_fire && !bus.host_we)
        bus.host_rdata <= host_in_range ? mem[host_idx] : 32'h0;
      if (!bus.mem_we)
        bus.mem_read_data <= (eng_owner && eng_in_range) ? mem[eng_idx] : 32'h0;
      if ((host_fire && !host_in_range) || (eng_access && !eng_in_range))
        oob_err <= 1'b1;
      if (bus.mem_we && !eng_owner)
        conflict_err <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; contents
  // survive a reset by design.
  always_ff @(posedge clk) begin
    if (eng_wr_ok)       mem[eng_idx]  <= bus.mem_write_data;
    else if (host_wr_ok) mem[host_idx] <= bus.host_wdata;
  end

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Self-checking bench for sha256_mem_responder: randomized host/engine traffic
// checked against a word-array + window-set reference model.
module tb_sha256_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        engine_start, result_clear, result_ready, oob_err, conflict_err;
  logic [15:0] win_base;

  sha256_mem_responder_if bus ();

  sha256_mem_responder #(.DEPTH(1024), .OUT_WORDS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .engine_start (engine_start),
    .win_base     (win_base),
    .result_ready (result_ready),
    .result_clear (result_clear),
    .oob_err      (oob_err),
    .conflict_err (conflict_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: memory image, who owns it, and which window words landed.
  logic [31:0] ref_mem [1024];
  bit          ref_engine_owns;
  bit          ref_complete;
  bit          ref_seen [8];
  int          ref_base;

  function automatic bit all_seen();
    for (int i = 0; i < 8; i++) if (!ref_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.mem_addr = '0; bus.mem_we = 1'b0; bus.mem_write_data = '0;
    bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    engine_start = 1'b0; win_base = '0; result_clear = 1'b0;
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'(a); bus.host_wdata = d;
    tick();
    bus.host_valid = 1'b0; bus.host_we = 1'b0;
    if (!ref_engine_owns && a < 1024) ref_mem[a] = d;
  endtask

  task automatic host_rd(input int a, output logic [31:0] d, output logic v);
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'(a);
    tick();
    d = bus.host_rdata; v = bus.host_rvalid;
    bus.host_valid = 1'b0;
  endtask

  task automatic eng_wr(input int a, input logic [31:0] d);
    bus.mem_we = 1'b1; bus.mem_addr = 16'(a); bus.mem_write_data = d;
    tick();
    bus.mem_we = 1'b0;
    if (ref_engine_owns && a < 1024) begin
      ref_mem[a] = d;
      if (a >= ref_base && a < ref_base + 8) ref_seen[a - ref_base] = 1'b1;
      if (all_seen()) begin ref_engine_owns = 1'b0; ref_complete = 1'b1; end
    end
  endtask

  task automatic eng_rd(input int a, output logic [31:0] d);
    bus.mem_we = 1'b0; bus.mem_addr = 16'(a);
    tick();
    d = bus.mem_read_data;
  endtask

  task automatic start_engine(input int base);
    engine_start = 1'b1; win_base = 16'(base);
    tick();
    engine_start = 1'b0;
    ref_engine_owns = 1'b1; ref_complete = 1'b0; ref_base = base;
    for (int i = 0; i < 8; i++) ref_seen[i] = 1'b0;
  endtask

  task automatic clear_result();
    result_clear = 1'b1;
    tick();
    result_clear = 1'b0;
    ref_complete = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (bus.host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %b want 1", bus.host_ready); end
    n_cmp++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL reset_result_ready: got %b want 0", result_ready); end
    n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.host_rvalid); end
    n_cmp++; if (bus.host_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.host_rdata); end
    n_cmp++; if (bus.mem_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_read_data); end
    n_cmp++; if ({oob_err, conflict_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {oob_err, conflict_err}); end
  endtask

  task automatic test_load();
    logic [31:0] d;
    logic        v;
    int          ra [8];
    for (int i = 0; i < 20; i++) host_wr(i, 32'hA5A5_0000 + 32'(i));
    for (int k = 0; k < 8; k++) begin
      ra[k] = $urandom_range(40, 255);
      host_wr(ra[k], $urandom);
    end
    // Back-to-back reads: valid held high, one acceptance per cycle.
    for (int i = 0; i < 20; i++) begin
      bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'(i);
      tick();
      n_cmp++;
      if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL load_readback[%0d]: got v=%b %h want v=1 %h", i, bus.host_rvalid, bus.host_rdata, ref_mem[i]);
      end
    end
    bus.host_valid = 1'b0;
    tick();
    n_cmp++; if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_rvalid_drop: got %b want 0", bus.host_rvalid); end
    for (int k = 0; k < 8; k++) begin
      host_rd(ra[k], d, v);
      n_cmp++; if (d !== ref_mem[ra[k]] || v !== 1'b1) begin n_fail++; $display("FAIL load_random[%0d]: got %h want %h", ra[k], d, ref_mem[ra[k]]); end
    end
  endtask

  task automatic test_engine_round_trip();
    logic [31:0] d, hdat;
    logic        v;
    eng_rd(5, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL host_state_eng_read: got %h want 0", d); end
    // Start coincides with a host write and an engine read.
    hdat = $urandom;
    engine_start = 1'b1; win_base = 16'h0100;
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'd30; bus.host_wdata = hdat;
    bus.mem_addr = 16'd5; bus.mem_we = 1'b0;
    ref_mem[30] = hdat;
    tick();
    drive_idle();
    ref_engine_owns = 1'b1; ref_complete = 1'b0; ref_base = 16'h0100;
    for (int i = 0; i < 8; i++) ref_seen[i] = 1'b0;
    n_cmp++; if (bus.mem_read_data !== 32'h0) begin n_fail++; $display("FAIL start_cycle_eng_read: got %h want 0", bus.mem_read_data); end
    n_cmp++; if (bus.host_ready !== 1'b0) begin n_fail++; $display("FAIL engine_host_ready: got %b want 0", bus.host_ready); end
    eng_rd(5, d);
    n_cmp++; if (d !== 32'hA5A5_0005) begin n_fail++; $display("FAIL engine_read5: got %h want a5a50005", d); end
    for (int k = 0; k < 8; k++) begin
      eng_wr(16'h0100 + k, 32'hD0 + 32'(k));
      n_cmp++; if (result_ready !== ref_complete) begin n_fail++; $display("FAIL rt_result_ready[%0d]: got %b want %b", k, result_ready, ref_complete); end
    end
    n_cmp++; if (bus.host_ready !== 1'b1) begin n_fail++; $display("FAIL complete_host_ready: got %b want 1", bus.host_ready); end
    for (int k = 0; k < 8; k++) begin
      host_rd(16'h0100 + k, d, v);
      n_cmp++; if (d !== 32'hD0 + 32'(k) || v !== 1'b1) begin n_fail++; $display("FAIL rt_digest[%0d]: got %h want %h", k, d, 32'hD0 + 32'(k)); end
    end
    host_rd(30, d, v);
    n_cmp++; if (d !== ref_mem[30]) begin n_fail++; $display("FAIL start_host_write: got %h want %h", d, ref_mem[30]); end
    // Clear and start together: clear wins, engine must not own memory.
    result_clear = 1'b1; engine_start = 1'b1; win_base = 16'h0200;
    tick();
    drive_idle();
    ref_complete = 1'b0;
    n_cmp++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL clear_start_ready: got %b want 0", result_ready); end
    eng_rd(5, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_start_state: got %h want 0", d); end
  endtask

  task automatic test_partial_dup();
    logic [31:0] d, first, dup;
    logic        v;
    int          off [8];
    int          base, tmp, j, a;
    start_engine(16'h0100);
    first = $urandom; dup = $urandom;
    eng_wr(16'h0100, first);
    for (int k = 1; k < 7; k++) eng_wr(16'h0100 + k, $urandom);
    eng_wr(16'h0100, dup);
    n_cmp++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL partial_ready: got %b want 0", result_ready); end
    eng_wr(16'h0107, $urandom);
    n_cmp++; if (result_ready !== 1'b1) begin n_fail++; $display("FAIL partial_final_ready: got %b want 1", result_ready); end
    host_rd(16'h0100, d, v);
    n_cmp++; if (d !== dup) begin n_fail++; $display("FAIL dup_overwrite: got %h want %h", d, dup); end
    clear_result();
    // Randomized window: random base, shuffled order, duplicates and distractors.
    for (int r = 0; r < 3; r++) begin
      base = $urandom_range(16'h0200, 1024 - 8);
      start_engine(base);
      for (int i = 0; i < 8; i++) off[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(0, i); tmp = off[i]; off[i] = off[j]; off[j] = tmp;
      end
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          do a = $urandom_range(0, 1023); while (a >= base && a < base + 8);
          eng_wr(a, $urandom);
        end
        if (k > 0 && $urandom_range(0, 2) == 0) eng_wr(base + off[$urandom_range(0, k - 1)], $urandom);
        eng_wr(base + off[k], $urandom);
        n_cmp++; if (result_ready !== ref_complete) begin n_fail++; $display("FAIL rand_ready[%0d.%0d]: got %b want %b", r, k, result_ready, ref_complete); end
      end
      for (int k = 0; k < 8; k++) begin
        host_rd(base + k, d, v);
        n_cmp++; if (d !== ref_mem[base + k]) begin n_fail++; $display("FAIL rand_digest[%0d]: got %h want %h", base + k, d, ref_mem[base + k]); end
      end
      clear_result();
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        v;
    n_cmp++; if ({oob_err, conflict_err} !== 2'b00) begin n_fail++; $display("FAIL err_pre: got %b want 00", {oob_err, conflict_err}); end
    eng_wr(10, 32'hDEAD_BEEF);
    n_cmp++; if (conflict_err !== 1'b1) begin n_fail++; $display("FAIL conflict_set: got %b want 1", conflict_err); end
    host_rd(10, d, v);
    n_cmp++; if (d !== ref_mem[10]) begin n_fail++; $display("FAIL conflict_no_write: got %h want %h", d, ref_mem[10]); end
    host_wr(976, $urandom);
    host_wr(2000, $urandom);
    n_cmp++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_write_set: got %b want 1", oob_err); end
    host_rd(2000, d, v);
    n_cmp++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL oob_read: got v=%b %h want v=1 0", v, d); end
    host_rd(976, d, v);
    n_cmp++; if (d !== ref_mem[976]) begin n_fail++; $display("FAIL oob_no_alias: got %h want %h", d, ref_mem[976]); end
    clear_result();
    n_cmp++; if ({oob_err, conflict_err, bus.host_ready} !== 3'b111) begin n_fail++; $display("FAIL clear_in_host: got %b want 111", {oob_err, conflict_err, bus.host_ready}); end
    start_engine(16'h0300);
    for (int k = 0; k < 8; k++) eng_wr(16'h0300 + k, $urandom);
    clear_result();
    n_cmp++; if ({oob_err, conflict_err, result_ready} !== 3'b110) begin n_fail++; $display("FAIL flags_persist: got %b want 110", {oob_err, conflict_err, result_ready}); end
  endtask

  task automatic test_reset_mid_engine();
    logic [31:0] d;
    logic        v;
    start_engine(16'h0100);
    for (int k = 0; k < 3; k++) eng_wr(16'h0100 + k, 32'hE0 + 32'(k));
    eng_rd(16'h0100, d);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_engine_owns = 1'b0; ref_complete = 1'b0;
    n_cmp++; if ({bus.host_ready, result_ready, bus.host_rvalid} !== 3'b100) begin n_fail++; $display("FAIL midrst_ctrl: got %b want 100", {bus.host_ready, result_ready, bus.host_rvalid}); end
    n_cmp++; if ({bus.mem_read_data, bus.host_rdata} !== 64'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", {bus.mem_read_data, bus.host_rdata}); end
    n_cmp++; if ({oob_err, conflict_err} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b want 00", {oob_err, conflict_err}); end
    for (int k = 0; k < 3; k++) begin
      host_rd(16'h0100 + k, d, v);
      n_cmp++; if (d !== 32'hE0 + 32'(k)) begin n_fail++; $display("FAIL midrst_retained[%0d]: got %h want %h", k, d, 32'hE0 + 32'(k)); end
    end
    start_engine(16'h0100);
    for (int k = 3; k < 8; k++) eng_wr(16'h0100 + k, $urandom);
    n_cmp++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_mask_clear: got %b want 0", result_ready); end
    for (int k = 0; k < 3; k++) eng_wr(16'h0100 + k, $urandom);
    n_cmp++; if (result_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_complete: got %b want 1", result_ready); end
    clear_result();
  endtask

  initial begin
    drive_idle();
    ref_engine_owns = 1'b0; ref_complete = 1'b0; ref_base = 0;
    for (int i = 0; i < 8; i++) ref_seen[i] = 1'b0;
    test_reset();
    test_load();
    test_engine_round_trip();
    test_partial_dup();
    test_errors();
    test_reset_mid_engine();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_mem_responder.md
# sha256_mem_responder

Word-addressed memory responder serving the SHA-256 engine's memory master port (`mem_addr`/`mem_we`/`mem_write_data` in, `mem_read_data` out). It holds the message and result buffer, arbitrates ownership between a host load/unload port and the engine, and tracks the 8-word digest write-back window, flagging completion and protocol errors. It sits between the testbench or host and the hash core.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; valid addresses are 0..DEPTH-1.
- `OUT_WORDS`, 8: number of words in the digest window.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `mem_addr`  in  16  engine word address.
- `mem_we`  in  1  engine write enable.
- `mem_write_data`  in  32  engine write data.
- `mem_read_data`  out  32  engine read data, registered.
- `host_valid`  in  1  host request.
- `host_ready`  out  1  host request accepted when `host_valid && host_ready`.
- `host_we`  in  1  host write (1) or read (0).
- `host_addr`  in  16  host word address.
- `host_wdata`  in  32  host write data.
- `host_rdata`  out  32  host read data.
- `host_rvalid`  out  1  one-cycle pulse qualifying `host_rdata`.
- `engine_start`  in  1  the same pulse that starts the engine; hands memory ownership to the engine.
- `win_base`  in  16  digest window base, which is the engine's `output_addr`. Sampled on `engine_start`.
- `result_ready`  out  1  all `OUT_WORDS` window words have been written.
- `result_clear`  in  1  returns ownership to the host.
- `oob_err`  out  1  sticky flag: an out-of-range access occurred.
- `conflict_err`  out  1  sticky flag: the engine wrote while it did not own the memory.

## Operation
- The FSM has three states: HOST, ENGINE and COMPLETE.
- **HOST**
  - `host_ready`=1.
  - Engine reads return 0.
  - Engine writes are dropped and set `conflict_err`.
  - `engine_start`=1 moves to ENGINE, latches `win_base` and clears the window mask. A host request presented in the same cycle is still accepted.
- **ENGINE**
  - `host_ready`=0.
  - Engine reads and writes are serviced.
  - A write to an address `A` with `win_base <= A < win_base+OUT_WORDS` sets mask bit `A-win_base`. The comparison uses 17-bit arithmetic, so the window never wraps.
  - A repeat write to an already-marked word updates the data; the mask is unchanged.
  - When the mask is all ones, move to COMPLETE.
  - `engine_start` is ignored in this state.
- **COMPLETE**
  - `result_ready`=1 and `host_ready`=1; the host reads the digest.
  - Engine writes are dropped and set `conflict_err`.
  - `result_clear`=1 moves to HOST and clears the mask. If `result_clear` and `engine_start` arrive in the same cycle, clear wins and start is ignored.
- **Out of range** (address >= DEPTH, on either port)
  - Reads return 32'h0.
  - Writes are dropped.
  - `oob_err` is set.
- `result_clear` is ignored in HOST and ENGINE.
- Error flags clear only on `reset`.
- The memory array is not reset.

## Timing
- **Reset values:** state=HOST, `mem_read_data`=0, `host_rdata`=0, `host_rvalid`=0, `result_ready`=0, `oob_err`=0, `conflict_err`=0, mask=0. `host_ready` is 1, since it is combinational from state.
- **Engine read:** address sampled at edge N; `mem_read_data` is valid after edge N, i.e. usable at edge N+1. The output holds its value until the next engine read.
- **Engine write:** committed at the sampling edge. The mask updates at the same edge.
- **Read-during-write** to the same address returns the old data on both ports.
- **Host read:** accepted at edge N; `host_rvalid`=1 and `host_rdata` valid during cycle N+1. Back-to-back requests sustain one per cycle.
- **Ownership transfers:** `result_ready` rises the cycle after the final window write. ENGINE is entered the cycle after `engine_start`, so an engine read issued in that same start cycle returns 0.
- **Reset mid-ENGINE or mid-COMPLETE:** returns to HOST next cycle with the reset values above; memory contents are retained.

## Test plan
- **Load and read-back:** host writes 32'hA5A5_0000+i to addresses 0..19, then reads them back. Expect one `host_rvalid` per read, the cycle after acceptance, with matching data.
- **Engine round trip:** after load, pulse `engine_start` with `win_base`=16'h0100. Engine reads address 5, expecting 32'hA5A5_0005 one cycle later. Engine writes 32'hD0+k to 0x100..0x107. Expect `result_ready`=1 the cycle after the 0x107 write; host reads 0x100..0x107 and sees 32'hD0..32'hD7.
- **Partial and duplicate window writes:** write 0x100 twice and 0x101..0x106 once, skipping 0x107. `result_ready` stays 0 and the duplicate overwrites the data. Writing 0x107 then asserts `result_ready`.
- **Errors:** engine write while in HOST sets `conflict_err`=1 and leaves memory unchanged. Host read of address 2000 (DEPTH=1024) returns 0 and sets `oob_err`=1. Both flags persist through `result_clear`.
- **Simultaneous events:**
  - `engine_start` with a host write in HOST: the write lands and the state goes to ENGINE.
  - `result_clear` with `engine_start` in COMPLETE: the state goes to HOST, not ENGINE.
- **Reset mid-ENGINE:** assert `reset` after 3 window writes. All outputs return to reset values, state is HOST, and the mask is 0. Host reads show the previously written data intact.
